// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and stall sequencer for the 5-stage pipeline.
// Drives PC / IF/ID / ID/EX write enables plus bubble and flush controls.
// It handles three conditions:
//   - load-use stalls against the ID/EX stage,
//   - flushes of wrong-path instructions on taken branches,
//   - front-end freezes while data memory is busy.
// It also keeps saturating stall/flush counters and a sticky memory-timeout flag.
module pipeline_hazard_ctrl #(
  parameter int REG_W       = 5,
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             idex_memRead,
  input  logic [REG_W-1:0] idex_rt,
  input  logic [REG_W-1:0] ifid_rs,
  input  logic [REG_W-1:0] ifid_rt,
  input  logic             ifid_usesRt,
  input  logic             ex_branchTaken,
  input  logic             mem_busy,
  output logic             pcWrite,
  output logic             ifidWrite,
  output logic             idexWrite,
  output logic             idexBubble,
  output logic             ifidFlush,
  output logic             idexFlush,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stallCount,
  output logic [CNT_W-1:0] flushCount,
  output logic             memTimeout
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    FLUSH      = 2'd2,
    MEM_WAIT   = 2'd3
  } state_e;

  // Wait counter only needs to reach MEM_TIMEOUT, where it parks.
  localparam int                WAIT_W   = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

  state_e             state_q, state_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;
  logic               timeout_q, timeout_d;
  logic               load_use;
  logic               flush_evt;

  // Load-use hazard: EX holds a load whose destination feeds the ID instruction.
  // r0 is never a real dependency.
  always_comb begin
    load_use = idex_memRead && (idex_rt != '0) &&
               ((idex_rt == ifid_rs) || (ifid_usesRt && (idex_rt == ifid_rt)));
  end

  // Next-state and control outputs.
  // Priority: reset, then mem_busy, then taken branch, then load-use.
  always_comb begin
    pcWrite    = 1'b1;
    ifidWrite  = 1'b1;
    idexWrite  = 1'b1;
    idexBubble = 1'b0;
    ifidFlush  = 1'b0;
    idexFlush  = 1'b0;
    state_d    = RUN;
    wait_d     = wait_q;
    flush_evt  = 1'b0;

    if (reset) begin
      // Hold the front end and fill the pipeline registers with NOPs.
      pcWrite    = 1'b0;
      ifidWrite  = 1'b0;
      idexBubble = 1'b1;
      ifidFlush  = 1'b1;
      idexFlush  = 1'b1;
      wait_d     = '0;
    end else if (mem_busy) begin
      // Freeze everything while data memory is busy, from any state.
      pcWrite   = 1'b0;
      ifidWrite = 1'b0;
      idexWrite = 1'b0;
      state_d   = MEM_WAIT;
      wait_d    = (wait_q == WAIT_MAX) ? wait_q : wait_q + WAIT_W'(1);
    end else begin
      // Leaving MEM_WAIT behaves exactly like RUN in the same cycle.
      wait_d = '0;
      case (state_q)
        RUN, MEM_WAIT: begin
          if (ex_branchTaken) begin
            // Any concurrent load-use stall belongs to the wrong path.
            ifidFlush = 1'b1;
            idexFlush = 1'b1;
            flush_evt = 1'b1;
            state_d   = FLUSH;
          end else if (load_use) begin
            pcWrite    = 1'b0;
            ifidWrite  = 1'b0;
            idexBubble = 1'b1;
            state_d    = LOAD_STALL;
          end
        end
        LOAD_STALL: begin
          // EX now holds the bubble, so no load-use check here.
          if (ex_branchTaken) begin
            ifidFlush = 1'b1;
            idexFlush = 1'b1;
            flush_evt = 1'b1;
            state_d   = FLUSH;
          end
        end
        FLUSH: begin
          // EX holds the flushed NOP; branch and load-use are both stale.
          state_d = RUN;
        end
        default: state_d = RUN;
      endcase
    end
  end

  // Saturating performance counters and the sticky timeout flag.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!pcWrite && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (flush_evt && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
    timeout_d = timeout_q | (mem_busy && (wait_d == WAIT_MAX));
  end

  // State register; reset clears all bookkeeping.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= RUN;
      wait_q      <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  assign state      = state_q;
  assign stallCount = stall_cnt_q;
  assign flushCount = flush_cnt_q;
  assign memTimeout = timeout_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Testbench for pipeline_hazard_ctrl.
// A behavioural model tracks the pipeline situation and checks every cycle.
// Directed scenarios pin the model with literal expectations.
// Randomized traffic then exercises counter saturation and long memory waits.
module tb_pipeline_hazard_ctrl;
  localparam int RW  = 5;
  localparam int TO  = 64;
  localparam int CW  = 4;   // small counters so saturation is reachable
  localparam int CMAX = (1 << CW) - 1;

  logic clock = 1'b0;
  logic reset, idex_memRead, ifid_usesRt, ex_branchTaken, mem_busy;
  logic [RW-1:0] idex_rt, ifid_rs, ifid_rt;
  logic pcWrite, ifidWrite, idexWrite, idexBubble, ifidFlush, idexFlush, memTimeout;
  logic [1:0] dut_state;
  logic [CW-1:0] stallCount, flushCount;

  pipeline_hazard_ctrl #(.REG_W(RW), .MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset),
    .idex_memRead(idex_memRead), .idex_rt(idex_rt),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_usesRt(ifid_usesRt),
    .ex_branchTaken(ex_branchTaken), .mem_busy(mem_busy),
    .pcWrite(pcWrite), .ifidWrite(ifidWrite), .idexWrite(idexWrite),
    .idexBubble(idexBubble), .ifidFlush(ifidFlush), .idexFlush(idexFlush),
    .state(dut_state), .stallCount(stallCount), .flushCount(flushCount),
    .memTimeout(memTimeout)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  // Model: situation 0=running, 1=just stalled, 2=just flushed, 3=waiting on memory
  int m_state = 0, m_wait = 0, m_stall = 0, m_flush = 0;
  bit m_to = 1'b0;
  // Outputs sampled in the most recent cycle, for literal checks
  bit c_pc, c_ifid, c_idex, c_bub, c_iff, c_idf;

  task automatic check_lit(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Apply one cycle of inputs, compare all outputs against the model, advance the model.
  task automatic drive(input bit rst, input bit mr, input int irt, input int rs,
                       input int rt, input bit ur, input bit br, input bit busy);
    bit lu;
    bit e_pc, e_ifid, e_idex, e_bub, e_iff, e_idf;
    int n_state, n_wait, n_stall, n_flush;
    bit n_to;
    @(negedge clock);
    reset = rst; idex_memRead = mr; idex_rt = RW'(irt); ifid_rs = RW'(rs);
    ifid_rt = RW'(rt); ifid_usesRt = ur; ex_branchTaken = br; mem_busy = busy;
    #1;
    lu = mr && (irt != 0) && ((irt == rs) || (ur && (irt == rt)));
    {e_pc, e_ifid, e_idex, e_bub, e_iff, e_idf} = 6'b111000;
    n_state = 0; n_wait = m_wait; n_stall = m_stall; n_flush = m_flush; n_to = m_to;
    if (rst) begin
      {e_pc, e_ifid, e_idex, e_bub, e_iff, e_idf} = 6'b001111;
      n_wait = 0; n_stall = 0; n_flush = 0; n_to = 0;
    end else begin
      if (busy) begin
        {e_pc, e_ifid, e_idex} = 3'b000;
        n_state = 3;
        n_wait = (m_wait + 1 > TO) ? TO : m_wait + 1;
        if (n_wait == TO) n_to = 1'b1;
      end else begin
        n_wait = 0;
        if (br && m_state != 2) begin
          {e_iff, e_idf} = 2'b11;
          n_state = 2;
          if (n_flush < CMAX) n_flush++;
        end else if (lu && (m_state == 0 || m_state == 3)) begin
          {e_pc, e_ifid, e_bub} = 3'b001;
          n_state = 1;
        end
      end
      if (!e_pc && n_stall < CMAX) n_stall++;
    end
    n_vec++;
    if ({pcWrite, ifidWrite, idexWrite, idexBubble, ifidFlush, idexFlush} !==
        {e_pc, e_ifid, e_idex, e_bub, e_iff, e_idf}) begin
      n_err++;
      $display("FAIL controls t=%0t: got pc/ifid/idex/bub/iff/idf=%b, expected %b", $time,
               {pcWrite, ifidWrite, idexWrite, idexBubble, ifidFlush, idexFlush},
               {e_pc, e_ifid, e_idex, e_bub, e_iff, e_idf});
    end
    if ({dut_state, stallCount, flushCount, memTimeout} !==
        {2'(m_state), CW'(m_stall), CW'(m_flush), m_to}) begin
      n_err++;
      $display("FAIL regs t=%0t: got state=%0d stall=%0d flush=%0d to=%0b, expected %0d %0d %0d %0b",
               $time, dut_state, stallCount, flushCount, memTimeout,
               m_state, m_stall, m_flush, m_to);
    end
    {c_pc, c_ifid, c_idex, c_bub, c_iff, c_idf} =
      {pcWrite, ifidWrite, idexWrite, idexBubble, ifidFlush, idexFlush};
    @(posedge clock);
    #1;
    m_state = n_state; m_wait = n_wait; m_stall = n_stall; m_flush = n_flush; m_to = n_to;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    drive(1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int burst;
    bit rst, busy;
    reset = 1'b1; idex_memRead = 0; idex_rt = '0; ifid_rs = '0; ifid_rt = '0;
    ifid_usesRt = 0; ex_branchTaken = 0; mem_busy = 0;

    // Reset state
    do_reset(); do_reset();
    check_lit("rst_state", dut_state, 0);
    check_lit("rst_stall", stallCount, 0);

    // 1. Load then dependent use
    drive(0, 1, 5, 5, 0, 0, 0, 0);
    check_lit("lu_pc", c_pc, 0);
    check_lit("lu_ifid", c_ifid, 0);
    check_lit("lu_bubble", c_bub, 1);
    check_lit("lu_state", dut_state, 1);
    drive(0, 1, 5, 5, 0, 0, 0, 0);   // lu ignored in LOAD_STALL
    check_lit("ls_pc", c_pc, 1);
    check_lit("ls_state", dut_state, 0);
    check_lit("ls_stall", stallCount, 1);

    // 2. r0 and unused rt never stall
    drive(0, 1, 0, 0, 0, 1, 0, 0);
    check_lit("r0_pc", c_pc, 1);
    drive(0, 1, 7, 3, 7, 0, 0, 0);
    check_lit("rt_unused_pc", c_pc, 1);
    drive(0, 1, 7, 3, 7, 1, 0, 0);
    check_lit("rt_used_pc", c_pc, 0);
    idle();

    // 3. Branch coincident with load-use
    do_reset();
    drive(0, 1, 5, 5, 0, 0, 1, 0);
    check_lit("br_iff", c_iff, 1);
    check_lit("br_idf", c_idf, 1);
    check_lit("br_pc", c_pc, 1);
    check_lit("br_bub", c_bub, 0);
    check_lit("br_state", dut_state, 2);
    check_lit("br_flush", flushCount, 1);
    check_lit("br_stall", stallCount, 0);
    drive(0, 1, 5, 5, 0, 0, 1, 0);   // both ignored in FLUSH
    check_lit("fl_pc", c_pc, 1);
    check_lit("fl_flushcnt", flushCount, 1);

    // 4. mem_busy held 3 cycles during lu, then same-cycle stall on release
    do_reset();
    repeat (3) drive(0, 1, 5, 5, 0, 0, 0, 1);
    check_lit("mw_idex", c_idex, 0);
    check_lit("mw_state", dut_state, 3);
    drive(0, 1, 5, 5, 0, 0, 0, 0);
    check_lit("mw_exit_bub", c_bub, 1);
    check_lit("mw_exit_state", dut_state, 1);
    check_lit("mw_exit_stall", stallCount, 4);

    // 5. Memory timeout after 64 busy cycles; sticky until reset
    do_reset();
    repeat (TO - 1) drive(0, 0, 0, 0, 0, 0, 0, 1);
    check_lit("to_before", memTimeout, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    check_lit("to_set", memTimeout, 1);
    idle();
    check_lit("to_sticky", memTimeout, 1);

    // 6. Reset mid-MEM_WAIT with nonzero counters
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    check_lit("pre_rst_state", dut_state, 3);
    do_reset();
    check_lit("rst_pc", c_pc, 0);
    check_lit("rst_idex", c_idex, 1);
    check_lit("rst_bub", c_bub, 1);
    check_lit("rst_iff", c_iff, 1);
    check_lit("rst_state2", dut_state, 0);
    check_lit("rst_flush2", flushCount, 0);
    check_lit("rst_to2", memTimeout, 0);

    // Randomized traffic with occasional long memory waits
    burst = 0;
    for (int i = 0; i < 3000; i++) begin
      if (burst > 0) begin
        busy = 1'b1;
        burst--;
      end else begin
        busy = ($urandom_range(0, 5) == 0);
        if ($urandom_range(0, 199) == 0) burst = $urandom_range(10, 80);
      end
      rst = ($urandom_range(0, 149) == 0);
      drive(rst, $urandom_range(0, 1) == 1, $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 3), $urandom_range(0, 1) == 1,
            $urandom_range(0, 4) == 0, busy);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Hazard and stall sequencer for the 5-stage pipeline. It drives the write enables, bubble and flush controls of the PC, IF/ID and ID/EX pipeline registers. It detects load-use hazards against the ID/EX stage, flushes wrong-path instructions on taken branches, and freezes the front end while data memory is busy. It also keeps saturating stall and flush performance counters and a sticky memory-timeout flag.

Parameters:
REG_W, 5, register-index width
MEM_TIMEOUT, 64, consecutive mem_busy cycles before memTimeout sets (minimum 2)
CNT_W, 16, width of the performance counters

Ports:
clock  in  1  system clock; all state updates on the rising edge
reset  in  1  synchronous, active-high reset
idex_memRead  in  1  memRead control of the instruction currently in EX (ID/EX output)
idex_rt  in  REG_W  load destination register of the EX instruction (ID/EX rt output)
ifid_rs  in  REG_W  rs field of the instruction in ID
ifid_rt  in  REG_W  rt field of the instruction in ID
ifid_usesRt  in  1  ID instruction reads rt (R-type, store, branch)
ex_branchTaken  in  1  branch in EX resolved taken (branch AND zero)
mem_busy  in  1  data memory requests a wait this cycle
pcWrite  out  1  PC load enable
ifidWrite  out  1  IF/ID load enable
idexWrite  out  1  ID/EX load enable
idexBubble  out  1  ID/EX loads all-zero control fields instead of decoded controls
ifidFlush  out  1  IF/ID loads a NOP
idexFlush  out  1  ID/EX loads a NOP
state  out  2  current FSM state (debug)
stallCount  out  CNT_W  cycles with pcWrite=0, saturating
flushCount  out  CNT_W  taken-branch flushes, saturating
memTimeout  out  1  sticky error flag

Behaviour:
- Control outputs are combinational from state and inputs. state, the counters, the wait counter and memTimeout are registered.
- States: RUN=0, LOAD_STALL=1, FLUSH=2, MEM_WAIT=3.
- Defaults: pcWrite=ifidWrite=idexWrite=1; idexBubble=ifidFlush=idexFlush=0.
- Load-use hazard: lu = idex_memRead & (idex_rt!=0) & (idex_rt==ifid_rs | (ifid_usesRt & idex_rt==ifid_rt)).
- Priority when evaluating (RUN, LOAD_STALL, or MEM_WAIT with mem_busy=0):
  1. mem_busy
  2. ex_branchTaken
  3. lu
- mem_busy=1 (any state): pcWrite=ifidWrite=idexWrite=0, no bubble or flush; next state MEM_WAIT. The wait counter increments, saturating at MEM_TIMEOUT; memTimeout sets when the counter reaches MEM_TIMEOUT.
- MEM_WAIT with mem_busy=0: wait counter clears, then evaluate exactly as RUN in the same cycle (zero extra latency).
- ex_branchTaken (RUN, LOAD_STALL, MEM_WAIT exit): ifidFlush=idexFlush=1, pcWrite=1. Any concurrent lu stall is dropped because it is wrong-path. flushCount++; next state FLUSH.
- lu (RUN, MEM_WAIT exit): pcWrite=ifidWrite=0, idexBubble=1; next state LOAD_STALL. Stall length is exactly 1 cycle.
- LOAD_STALL: lu is ignored (EX now holds the bubble); branch rule still applies; otherwise defaults; next state RUN.
- FLUSH: ex_branchTaken and lu are ignored (EX holds the flushed NOP); defaults; next state RUN. mem_busy still takes priority.
- Counters: stallCount increments in every non-reset cycle with pcWrite=0. Both counters saturate at all-ones and never wrap.
- reset=1 (at any time, including mid-MEM_WAIT or FLUSH):
  - outputs forced to pcWrite=ifidWrite=0, idexWrite=1, idexBubble=1, ifidFlush=idexFlush=1
  - next state RUN; counters, wait counter and memTimeout cleared
  - counters do not count reset cycles
- memTimeout clears only on reset.

Test Plan:
1. Load then dependent use: idex_memRead=1, idex_rt=5, ifid_rs=5 in RUN -> that cycle pcWrite=0, ifidWrite=0, idexBubble=1; next cycle state=1 with defaults; following cycle state=0; stallCount=1.
2. Load to r0 and non-matching rt: idex_rt=0, ifid_rs=0 -> no stall. idex_rt=7, ifid_rt=7, ifid_usesRt=0 -> no stall.
3. Branch coincident with load-use: ex_branchTaken=1 and lu=1 in RUN -> ifidFlush=idexFlush=1, pcWrite=1, no bubble; state=2 next; flushCount=1; stallCount unchanged.
4. mem_busy held 3 cycles during lu -> 3 cycles of all enables 0, state=3. On release: same-cycle lu stall (bubble) -> state=1; stallCount=4.
5. mem_busy held 64 cycles -> memTimeout rises after cycle 64 and stays 1 after mem_busy drops; cleared only by a 1-cycle reset.
6. Reset asserted while in MEM_WAIT with counters nonzero -> forced reset outputs that cycle; next cycle state=0, stallCount=flushCount=0, memTimeout=0.
